// File: rtl/hammu_axi_pkg.sv
// Shared FSM encoding and AXI response codes for hammu_axi_master.
package hammu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WR_B  = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/hammu_axi_master.sv
// Single-beat AXI4 master: one command in, one AXI read or write, one response out.
// Latency: 3 cycles accept-to-RSP_VALID with a zero-wait slave; every AXI output registered.
// Backpressure: one command in flight, CMD_READY only in IDLE; HAMMU_AXI_MASTER_TIMEOUT_EN bounds handshake waits.
module hammu_axi_master
    import hammu_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    input  logic                            CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,

    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]                      RSP_RESP,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    if (C_M_AXI_DATA_WIDTH != 32 || C_TIMEOUT < 1) begin : g_cfg_check
        $error("hammu_axi_master: data width must be 32 and C_TIMEOUT at least 1");
    end

    state_t                          state_q,     state_nxt;
    logic                            cmd_rdy_q,   cmd_rdy_nxt;
    logic                            aw_vld_q,    aw_vld_nxt;
    logic                            w_vld_q,     w_vld_nxt;
    logic                            b_rdy_q,     b_rdy_nxt;
    logic                            ar_vld_q,    ar_vld_nxt;
    logic                            r_rdy_q,     r_rdy_nxt;
    logic                            rsp_vld_q,   rsp_vld_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_nxt;
    logic [1:0]                      rsp_resp_q,  rsp_resp_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,      addr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_nxt;
    logic                            tmo_hit;
    logic                            tmo_take;

`ifdef HAMMU_AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_wait;

    assign in_wait = state_q inside {ST_WR, ST_WR_B, ST_RD_AR, ST_RD_R};
    assign tmo_hit = in_wait && (tmo_cnt == TW'(C_TIMEOUT - 1));

    // Restarts on every state change, so each wait state gets its own budget.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_cnt <= '0;
        end else if (!in_wait || state_nxt != state_q) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state_q;
        cmd_rdy_nxt   = cmd_rdy_q;
        aw_vld_nxt    = aw_vld_q;
        w_vld_nxt     = w_vld_q;
        b_rdy_nxt     = b_rdy_q;
        ar_vld_nxt    = ar_vld_q;
        r_rdy_nxt     = r_rdy_q;
        rsp_vld_nxt   = rsp_vld_q;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_resp_nxt  = rsp_resp_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        tmo_take      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_rdy_nxt = 1'b1;
                if (CMD_VALID && cmd_rdy_q) begin
                    cmd_rdy_nxt = 1'b0;
                    addr_nxt    = CMD_ADDR;
                    wdata_nxt   = CMD_WDATA;
                    if (CMD_WRITE) begin
                        state_nxt  = ST_WR;
                        aw_vld_nxt = 1'b1;
                        w_vld_nxt  = 1'b1;
                    end else begin
                        state_nxt  = ST_RD_AR;
                        ar_vld_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; move on once neither is outstanding.
                aw_vld_nxt = aw_vld_q && !M_AXI_AWREADY;
                w_vld_nxt  = w_vld_q  && !M_AXI_WREADY;
                if (!aw_vld_nxt && !w_vld_nxt) begin
                    state_nxt = ST_WR_B;
                    b_rdy_nxt = 1'b1;
                end else begin
                    tmo_take = tmo_hit;
                end
            end
            ST_WR_B: begin
                if (M_AXI_BVALID) begin
                    state_nxt     = ST_RSP;
                    b_rdy_nxt     = 1'b0;
                    rsp_vld_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = M_AXI_BRESP;
                end else begin
                    tmo_take = tmo_hit;
                end
            end
            ST_RD_AR: begin
                if (M_AXI_ARREADY) begin
                    state_nxt  = ST_RD_R;
                    ar_vld_nxt = 1'b0;
                    r_rdy_nxt  = 1'b1;
                end else begin
                    tmo_take = tmo_hit;
                end
            end
            ST_RD_R: begin
                if (M_AXI_RVALID) begin
                    state_nxt     = ST_RSP;
                    r_rdy_nxt     = 1'b0;
                    rsp_vld_nxt   = 1'b1;
                    rsp_rdata_nxt = M_AXI_RDATA;
                    rsp_resp_nxt  = M_AXI_RRESP;
                end else begin
                    tmo_take = tmo_hit;
                end
            end
            ST_RSP: begin
                if (RSP_READY) begin
                    state_nxt   = ST_IDLE;
                    rsp_vld_nxt = 1'b0;
                    cmd_rdy_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abandon the bus transaction entirely and report it as a timeout.
        if (tmo_take) begin
            state_nxt     = ST_RSP;
            aw_vld_nxt    = 1'b0;
            w_vld_nxt     = 1'b0;
            b_rdy_nxt     = 1'b0;
            ar_vld_nxt    = 1'b0;
            r_rdy_nxt     = 1'b0;
            rsp_vld_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_resp_nxt  = RESP_TIMEOUT;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            cmd_rdy_q   <= 1'b0;
            aw_vld_q    <= 1'b0;
            w_vld_q     <= 1'b0;
            b_rdy_q     <= 1'b0;
            ar_vld_q    <= 1'b0;
            r_rdy_q     <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            cmd_rdy_q   <= cmd_rdy_nxt;
            aw_vld_q    <= aw_vld_nxt;
            w_vld_q     <= w_vld_nxt;
            b_rdy_q     <= b_rdy_nxt;
            ar_vld_q    <= ar_vld_nxt;
            r_rdy_q     <= r_rdy_nxt;
            rsp_vld_q   <= rsp_vld_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_resp_q  <= rsp_resp_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
        end
    end

    assign CMD_READY     = cmd_rdy_q;
    assign RSP_VALID     = rsp_vld_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = aw_vld_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_vld_q;
    assign M_AXI_BREADY  = b_rdy_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = ar_vld_q;
    assign M_AXI_RREADY  = r_rdy_q;

endmodule
